// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundles both requester ports and the single dmem port of
// the data-memory arbiter. The arbiter uses the 'slave' view; requesters and
// the memory model use the 'master' view.
interface dmem_arbiter_if;
   logic        m0_req;
   logic [31:0] m0_addr;
   logic [31:0] m0_wdata;
   logic        m0_wb;
   logic        m0_ww;
   logic        m0_rb;
   logic        m0_rw;
   logic        m0_gnt;
   logic        m0_done;
   logic [31:0] m0_rdata;

   logic        m1_req;
   logic [31:0] m1_addr;
   logic [31:0] m1_wdata;
   logic        m1_wb;
   logic        m1_ww;
   logic        m1_rb;
   logic        m1_rw;
   logic        m1_gnt;
   logic        m1_done;
   logic [31:0] m1_rdata;

   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_wb;
   logic        mem_ww;
   logic        mem_rb;
   logic        mem_rw;
   logic [31:0] mem_rdata;

   modport slave (
      input  m0_req, m0_addr, m0_wdata, m0_wb, m0_ww, m0_rb, m0_rw,
      input  m1_req, m1_addr, m1_wdata, m1_wb, m1_ww, m1_rb, m1_rw,
      input  mem_rdata,
      output m0_gnt, m0_done, m0_rdata,
      output m1_gnt, m1_done, m1_rdata,
      output mem_addr, mem_wdata, mem_wb, mem_ww, mem_rb, mem_rw
   );

   modport master (
      output m0_req, m0_addr, m0_wdata, m0_wb, m0_ww, m0_rb, m0_rw,
      output m1_req, m1_addr, m1_wdata, m1_wb, m1_ww, m1_rb, m1_rw,
      output mem_rdata,
      input  m0_gnt, m0_done, m0_rdata,
      input  m1_gnt, m1_done, m1_rdata,
      input  mem_addr, mem_wdata, mem_wb, mem_ww, mem_rb, mem_rw
   );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter/sequencer for the single dmem port.
// Requester 0 is the CPU load/store path, requester 1 the DMA/debug port.
// Each access holds the dmem strobes for ACCESS_CYCLES cycles (reads on every
// cycle, writes only on the final one), then a one-cycle RESP pulses done.
// All outputs are registered from next-state decode.
// Optional macro ARB_FIXED_PRIO_EN: requester 0 always wins an IDLE tie
// instead of round-robin.
module dmem_arbiter #(
   parameter int ACCESS_CYCLES = 1
) (
   input  logic           clk,
   input  logic           reset,
   dmem_arbiter_if.slave  bus
);
   localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   // Priority command decode ww > wb > rw > rb, one-hot {ww, wb, rw, rb}.
   function automatic logic [3:0] decode_op(input logic ww, input logic wb,
                                            input logic rw, input logic rb);
      logic [3:0] op;
      if (ww)      op = 4'b1000;
      else if (wb) op = 4'b0100;
      else if (rw) op = 4'b0010;
      else if (rb) op = 4'b0001;
      else         op = 4'b0000;
      return op;
   endfunction

   state_t      state_r, state_s;
   logic        owner_r, owner_s;
   logic        last_r, last_s;
   logic [3:0]  cnt_r, cnt_s;
   logic        tie_owner_s;
   logic [1:0]  req_s;
   logic [3:0]  op0_s, op1_s, op_cur_s, op_nxt_s;

   logic [1:0]  gnt_r, gnt_s;
   logic [1:0]  done_r, done_s;
   logic [31:0] mem_addr_r, mem_addr_s;
   logic [31:0] mem_wdata_r, mem_wdata_s;
   logic [3:0]  strb_r, strb_s;      // {ww, wb, rw, rb}
   logic [31:0] rdata0_r, rdata1_r;

   assign req_s    = {bus.m1_req, bus.m0_req};
   assign op0_s    = decode_op(bus.m0_ww, bus.m0_wb, bus.m0_rw, bus.m0_rb);
   assign op1_s    = decode_op(bus.m1_ww, bus.m1_wb, bus.m1_rw, bus.m1_rb);
   assign op_cur_s = owner_r ? op1_s : op0_s;
   assign op_nxt_s = owner_s ? op1_s : op0_s;

`ifdef ARB_FIXED_PRIO_EN
   assign tie_owner_s = 1'b0;
`else
   assign tie_owner_s = ~last_r;
`endif

   // Next-state logic: arbitration in IDLE/RESP, cycle counting in ACCESS.
   always_comb begin
      state_s = state_r;
      owner_s = owner_r;
      cnt_s   = cnt_r;
      last_s  = last_r;
      case (state_r)
         IDLE: begin
            if (req_s == 2'b11) begin
               state_s = ACCESS;
               owner_s = tie_owner_s;
               cnt_s   = 4'd0;
            end else if (req_s[0]) begin
               state_s = ACCESS;
               owner_s = 1'b0;
               cnt_s   = 4'd0;
            end else if (req_s[1]) begin
               state_s = ACCESS;
               owner_s = 1'b1;
               cnt_s   = 4'd0;
            end else begin
               state_s = IDLE;
            end
         end
         ACCESS: begin
            cnt_s = cnt_r + 4'd1;
            if (cnt_r == LAST_CNT) begin
               state_s = RESP;
               last_s  = owner_r;
            end else begin
               state_s = ACCESS;
            end
         end
         RESP: begin
            // The owner's req is still high here, so only the other side counts.
            if (req_s[~owner_r]) begin
               state_s = ACCESS;
               owner_s = ~owner_r;
               cnt_s   = 4'd0;
            end else begin
               state_s = IDLE;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Output decode for the coming cycle, registered below.
   always_comb begin
      gnt_s       = 2'b00;
      done_s      = 2'b00;
      mem_addr_s  = 32'd0;
      mem_wdata_s = 32'd0;
      strb_s      = 4'b0000;
      if (state_s == ACCESS) begin
         gnt_s[owner_s] = 1'b1;
         mem_addr_s     = owner_s ? bus.m1_addr  : bus.m0_addr;
         mem_wdata_s    = owner_s ? bus.m1_wdata : bus.m0_wdata;
         strb_s[1:0]    = op_nxt_s[1:0];
         if (cnt_s == LAST_CNT) begin
            strb_s[3:2] = op_nxt_s[3:2];
         end else begin
            strb_s[3:2] = 2'b00;
         end
      end else if (state_s == RESP) begin
         gnt_s[owner_s]  = 1'b1;
         done_s[owner_s] = 1'b1;
      end else begin
         gnt_s  = 2'b00;
         done_s = 2'b00;
      end
   end

   // FSM state, owner, cycle counter and round-robin history.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
         owner_r <= 1'b0;
         cnt_r   <= 4'd0;
         last_r  <= 1'b1;
      end else begin
         state_r <= state_s;
         owner_r <= owner_s;
         cnt_r   <= cnt_s;
         last_r  <= last_s;
      end
   end

   // Registered grant/done/dmem outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         gnt_r       <= 2'b00;
         done_r      <= 2'b00;
         mem_addr_r  <= 32'd0;
         mem_wdata_r <= 32'd0;
         strb_r      <= 4'b0000;
      end else begin
         gnt_r       <= gnt_s;
         done_r      <= done_s;
         mem_addr_r  <= mem_addr_s;
         mem_wdata_r <= mem_wdata_s;
         strb_r      <= strb_s;
      end
   end

   // Capture read data on the final ACCESS cycle of a read.
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata0_r <= 32'd0;
         rdata1_r <= 32'd0;
      end else if ((state_r == ACCESS) && (cnt_r == LAST_CNT) &&
                   (op_cur_s[1] || op_cur_s[0])) begin
         if (owner_r) begin
            rdata1_r <= bus.mem_rdata;
         end else begin
            rdata0_r <= bus.mem_rdata;
         end
      end
   end

   assign bus.m0_gnt    = gnt_r[0];
   assign bus.m1_gnt    = gnt_r[1];
   assign bus.m0_done   = done_r[0];
   assign bus.m1_done   = done_r[1];
   assign bus.m0_rdata  = rdata0_r;
   assign bus.m1_rdata  = rdata1_r;
   assign bus.mem_addr  = mem_addr_r;
   assign bus.mem_wdata = mem_wdata_r;
   assign bus.mem_ww    = strb_r[3];
   assign bus.mem_wb    = strb_r[2];
   assign bus.mem_rw    = strb_r[1];
   assign bus.mem_rb    = strb_r[0];
endmodule
